exibe_sequencia: RTL and testbench



---
 rtl/exibe_sequencia.sv | 136 +++++++++++++
 tb/tb_exibe_sequencia.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/exibe_sequencia.sv
// Sequence presenter for the memory game: walks ROM addresses 0..limite and shows each move
// on the LEDs for TEMPO_ON cycles, then a dark gap of TEMPO_OFF cycles. Optional EXIBE_PAUSA_EN adds a pause input.
module exibe_sequencia #(
  parameter int TEMPO_ON  = 50000000,
  parameter int TEMPO_OFF = 25000000,
  parameter int TIMER_W   = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] limite,
  input  logic [3:0] dado,
`ifdef EXIBE_PAUSA_EN
  input  logic       pausa,
`endif
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       exibindo,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    BUSCA   = 3'd1,
    CARREGA = 3'd2,
    ACENDE  = 3'd3,
    APAGA   = 3'd4,
    PROXIMO = 3'd5,
    FIM     = 3'd6
  } estado_t;

  localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(TEMPO_ON - 1);
  localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(TEMPO_OFF - 1);

  estado_t            estado, prox_estado;
  logic [TIMER_W-1:0] timer;
  logic [3:0]         limite_reg;
  logic               hold;

  logic tmr_inc, tmr_clr, leds_load, leds_clr, end_clr, end_inc, lim_cap;

`ifdef EXIBE_PAUSA_EN
  assign hold = pausa;
`else
  assign hold = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) estado <= INICIAL;
    else        estado <= prox_estado;
  end

  // NOTE: every signal gets a default before the case, otherwise missing branches infer latches.
  always_comb begin
    prox_estado = estado;
    tmr_inc     = 1'b0;
    tmr_clr     = 1'b0;
    leds_load   = 1'b0;
    leds_clr    = 1'b0;
    end_clr     = 1'b0;
    end_inc     = 1'b0;
    lim_cap     = 1'b0;
    case (estado)
      INICIAL: begin
        if (iniciar) begin
          lim_cap     = 1'b1;
          end_clr     = 1'b1;
          prox_estado = BUSCA;
        end
      end
      BUSCA:   prox_estado = CARREGA;
      CARREGA: begin
        leds_load   = 1'b1;
        tmr_clr     = 1'b1;
        prox_estado = ACENDE;
      end
      ACENDE: begin
        if (!hold) begin
          if (timer == ON_LAST) begin
            leds_clr    = 1'b1;
            tmr_clr     = 1'b1;
            prox_estado = APAGA;
          end else begin
            tmr_inc = 1'b1;
          end
        end
      end
      APAGA: begin
        if (!hold) begin
          if (timer == OFF_LAST) begin
            tmr_clr     = 1'b1;
            prox_estado = PROXIMO;
          end else begin
            tmr_inc = 1'b1;
          end
        end
      end
      PROXIMO: begin
        // Compare before incrementing so limite=15 finishes without wrapping the address.
        if (endereco == limite_reg) begin
          prox_estado = FIM;
        end else begin
          end_inc     = 1'b1;
          prox_estado = BUSCA;
        end
      end
      FIM:     prox_estado = INICIAL;
      default: prox_estado = INICIAL;
    endcase
  end

  // NOTE: only a handful of control registers exist here, so all of them take the reset value.
  always_ff @(posedge clock) begin
    if (!reset) begin
      endereco   <= '0;
      leds       <= '0;
      timer      <= '0;
      limite_reg <= '0;
    end else begin
      if (lim_cap)        limite_reg <= limite;
      if (end_clr)        endereco   <= '0;
      else if (end_inc)   endereco   <= endereco + 4'd1;
      if (leds_load)      leds       <= dado;
      else if (leds_clr)  leds       <= '0;
      if (tmr_clr)        timer      <= '0;
      else if (tmr_inc)   timer      <= timer + 1'b1;
    end
  end

  assign pronto    = (estado == FIM);
  assign exibindo  = (estado != INICIAL) && (estado != FIM);
  assign db_estado = {1'b0, estado};

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for exibe_sequencia with TEMPO_ON=4, TEMPO_OFF=2 and a registered 16x4 ROM model.
module tb_exibe_sequencia;
  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int PER = ON + OFF + 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [3:0] limite = 4'd0;
  logic [3:0] dado;
  logic [3:0] endereco, leds, db_estado;
  logic       exibindo, pronto;
`ifdef EXIBE_PAUSA_EN
  logic       pausa = 1'b0;
`endif

  logic [3:0] rom [16];
  int total = 0;
  int bad   = 0;

  exibe_sequencia #(.TEMPO_ON(ON), .TEMPO_OFF(OFF), .TIMER_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .limite    (limite),
    .dado      (dado),
`ifdef EXIBE_PAUSA_EN
    .pausa     (pausa),
`endif
    .endereco  (endereco),
    .leds      (leds),
    .exibindo  (exibindo),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) dado <= rom[endereco];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts a run with limite=lim and checks every cycle through FIM and the return to INICIAL.
  // poke_c: cycle at which iniciar is pulsed and limite changed to 5. pause_c/pause_n: pausa window.
  task automatic run_seq(input int lim, input int poke_c, input int pause_c, input int pause_n);
    int last, e, m, p;
    logic [3:0] es, el, ee;
    iniciar = 1'b1;
    limite  = 4'(lim);
    step();
    iniciar = 1'b0;
    last = PER * (lim + 1) + pause_n;
    for (int c = 0; c <= last; c++) begin
      if (c <= pause_c)                e = c;
      else if (c <= pause_c + pause_n) e = pause_c;
      else                             e = c - pause_n;
      m = e / PER;
      p = e % PER;
      if (e == PER * (lim + 1)) begin
        es = 4'd6; el = 4'd0; ee = 4'(lim);
      end else begin
        ee = 4'(m);
        el = (p >= 2 && p < 2 + ON) ? rom[m] : 4'd0;
        if (p == 0)                 es = 4'd1;
        else if (p == 1)            es = 4'd2;
        else if (p < 2 + ON)        es = 4'd3;
        else if (p < 2 + ON + OFF)  es = 4'd4;
        else                        es = 4'd5;
      end
      check("db_estado", db_estado, es);
      check("leds", leds, el);
      check("endereco", endereco, ee);
      check("pronto", pronto, es == 4'd6);
      check("exibindo", exibindo, es != 4'd6);
      if (c == poke_c) begin
        iniciar = 1'b1;
        limite  = 4'd5;
      end else if (c == poke_c + 1) begin
        iniciar = 1'b0;
      end
`ifdef EXIBE_PAUSA_EN
      if (c == pause_c && pause_n > 0) pausa = 1'b1;
      if (c == pause_c + pause_n)      pausa = 1'b0;
`endif
      step();
    end
    check("back_idle", db_estado, 4'd0);
    check("idle_pronto", pronto, 1'b0);
    check("idle_leds", leds, 4'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'(i);
    rom[0] = 4'b0001;
    rom[1] = 4'b0010;
    rom[2] = 4'b0100;
    rom[3] = 4'b0000;

    step();
    step();
    check("rst_estado", db_estado, 4'd0);
    check("rst_leds", leds, 4'd0);
    check("rst_endereco", endereco, 4'd0);
    check("rst_pronto", pronto, 1'b0);
    check("rst_exibindo", exibindo, 1'b0);
    reset = 1'b1;
    step();
    step();
    check("idle_hold", db_estado, 4'd0);

    run_seq(2, -1, -1, 0);
    run_seq(0, -1, -1, 0);
    run_seq(15, -1, -1, 0);
    run_seq(2, 6, -1, 0);
`ifdef EXIBE_PAUSA_EN
    run_seq(0, -1, 3, 3);
`endif

    // Reset during ACENDE of move 1 (cycle 12 after the first BUSCA).
    iniciar = 1'b1;
    limite  = 4'd2;
    step();
    iniciar = 1'b0;
    repeat (12) step();
    check("pre_rst_estado", db_estado, 4'd3);
    check("pre_rst_leds", leds, 4'b0010);
    reset = 1'b0;
    step();
    check("mid_rst_leds", leds, 4'd0);
    check("mid_rst_endereco", endereco, 4'd0);
    check("mid_rst_estado", db_estado, 4'd0);
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      check("post_rst_pronto", pronto, 1'b0);
      check("post_rst_estado", db_estado, 4'd0);
    end

    // iniciar held high: a new run begins right after FIM returns to INICIAL.
    iniciar = 1'b1;
    limite  = 4'd0;
    step();
    check("held_busca", db_estado, 4'd1);
    repeat (PER) step();
    check("held_fim", pronto, 1'b1);
    step();
    check("held_inicial", db_estado, 4'd0);
    step();
    check("held_restart", db_estado, 4'd1);
    check("held_endereco", endereco, 4'd0);
    iniciar = 1'b0;
    reset   = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("final_idle", db_estado, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
